morse_char_sequencer: RTL and testbench

Upstream feeder for the piezo buzzer driver. Buffers incoming ASCII characters in a small FIFO and encodes each one into a morse length/pattern pair. Issues a one-cycle start to the driver, tracks the driver's busy handshake, and inserts the inter-letter and inter-word silences the driver does not produce. Sits between the character source (UART/keypad logic) and the buzzer driver, in the same 25 MHz clock domain.

---
 rtl/morse_char_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_morse_char_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_char_sequencer.sv
`timescale 1ns/1ps
// morse_char_sequencer
//   Feeds the piezo buzzer driver. ASCII characters are buffered in a small
//   FIFO, encoded to a morse length/pattern pair, issued to the driver with a
//   one-cycle start, and separated by inter-letter / inter-word silences that
//   the driver does not generate itself.
//
//   Optional feature macro: MORSE_DIGITS_EN (define to encode '0'-'9';
//   otherwise digits are reported as bad_char and dropped).
//
// Ports
//   clk, rst_n        25 MHz clock, synchronous active-low reset
//   char_valid/_data  character offered by the source (held until char_ready)
//   char_ready        FIFO not full
//   morse_start       one-cycle start pulse to the driver
//   morse_len/_pattern symbol count 1..5 / symbols LSB first (1 = dash)
//   drv_busy          driver busy handshake
//   seq_busy          FIFO non-empty or sequencer not idle
//   bad_char          one-cycle pulse, unsupported character dropped
//   drv_err           one-cycle pulse, driver never acknowledged a start
//   fifo_count        FIFO occupancy
module morse_char_sequencer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int LETTER_GAP_CYC = 10000000,
  parameter int WORD_GAP_CYC   = 20000000,
  parameter int ACK_TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          char_valid,
  input  logic [7:0]                    char_data,
  output logic                          char_ready,
  output logic                          morse_start,
  output logic [2:0]                    morse_len,
  output logic [4:0]                    morse_pattern,
  input  logic                          drv_busy,
  output logic                          seq_busy,
  output logic                          bad_char,
  output logic                          drv_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int TMAX_A = (LETTER_GAP_CYC > WORD_GAP_CYC) ? LETTER_GAP_CYC : WORD_GAP_CYC;
  localparam int TMAX   = (TMAX_A > ACK_TIMEOUT) ? TMAX_A : ACK_TIMEOUT;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [1:0] ENC_BAD   = 2'd0;
  localparam logic [1:0] ENC_SYM   = 2'd1;
  localparam logic [1:0] ENC_SPACE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_GAP
  } state_t;

  // ---------------- FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  assign char_ready = (count != CW'(FIFO_DEPTH));
  assign push       = char_valid && char_ready;
  assign fifo_count = count;

  // Storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= char_data;

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- encoder (head of FIFO) ----------------
  logic [7:0] head, fold;
  logic [1:0] enc_kind;
  logic [7:0] enc;          // {len[2:0], pattern[4:0]}

  assign head = mem[rd_ptr];
  assign fold = (head >= 8'h61 && head <= 8'h7A) ? head - 8'h20 : head;

  always_comb begin
    enc_kind = ENC_SYM;
    enc      = '0;
    case (fold)
      "A": enc = {3'd2, 5'b00010};
      "B": enc = {3'd4, 5'b00001};
      "C": enc = {3'd4, 5'b00101};
      "D": enc = {3'd3, 5'b00001};
      "E": enc = {3'd1, 5'b00000};
      "F": enc = {3'd4, 5'b00100};
      "G": enc = {3'd3, 5'b00011};
      "H": enc = {3'd4, 5'b00000};
      "I": enc = {3'd2, 5'b00000};
      "J": enc = {3'd4, 5'b01110};
      "K": enc = {3'd3, 5'b00101};
      "L": enc = {3'd4, 5'b00010};
      "M": enc = {3'd2, 5'b00011};
      "N": enc = {3'd2, 5'b00001};
      "O": enc = {3'd3, 5'b00111};
      "P": enc = {3'd4, 5'b00110};
      "Q": enc = {3'd4, 5'b01011};
      "R": enc = {3'd3, 5'b00010};
      "S": enc = {3'd3, 5'b00000};
      "T": enc = {3'd1, 5'b00001};
      "U": enc = {3'd3, 5'b00100};
      "V": enc = {3'd4, 5'b01000};
      "W": enc = {3'd3, 5'b00110};
      "X": enc = {3'd4, 5'b01001};
      "Y": enc = {3'd4, 5'b01101};
      "Z": enc = {3'd4, 5'b00011};
`ifdef MORSE_DIGITS_EN
      "0": enc = {3'd5, 5'b11111};
      "1": enc = {3'd5, 5'b11110};
      "2": enc = {3'd5, 5'b11100};
      "3": enc = {3'd5, 5'b11000};
      "4": enc = {3'd5, 5'b10000};
      "5": enc = {3'd5, 5'b00000};
      "6": enc = {3'd5, 5'b00001};
      "7": enc = {3'd5, 5'b00011};
      "8": enc = {3'd5, 5'b00111};
      "9": enc = {3'd5, 5'b01111};
`endif
      8'h20:   enc_kind = ENC_SPACE;
      default: enc_kind = ENC_BAD;
    endcase
  end

  // ---------------- sequencer FSM ----------------
  state_t        state, state_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic [2:0]    len_q, len_nx;
  logic [4:0]    pat_q, pat_nx;
  logic          bad_nx, err_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tmr   <= '0;
      len_q <= '0;
      pat_q <= '0;
    end else begin
      state <= state_nx;
      tmr   <= tmr_nx;
      len_q <= len_nx;
      pat_q <= pat_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    len_nx   = len_q;
    pat_nx   = pat_q;
    pop      = 1'b0;
    bad_nx   = 1'b0;
    err_nx   = 1'b0;
    case (state)
      S_IDLE:
        if (count != '0) state_nx = S_FETCH;
      S_FETCH: begin
        pop = 1'b1;
        case (enc_kind)
          ENC_SYM: begin
            // len/pattern only move here, so they stay put while the
            // driver latches them a cycle after the start pulse.
            len_nx   = enc[7:5];
            pat_nx   = enc[4:0];
            state_nx = S_ISSUE;
          end
          ENC_SPACE: begin
            tmr_nx   = TW'(WORD_GAP_CYC);
            state_nx = S_GAP;
          end
          default: begin
            bad_nx   = 1'b1;
            state_nx = S_IDLE;
          end
        endcase
      end
      S_ISSUE: begin
        tmr_nx   = TW'(ACK_TIMEOUT);
        state_nx = S_WAIT_ACK;
      end
      S_WAIT_ACK:
        if (drv_busy) begin
          state_nx = S_WAIT_DONE;
        end else if (tmr <= TW'(1)) begin
          err_nx   = 1'b1;
          state_nx = S_IDLE;
        end else begin
          tmr_nx = tmr - TW'(1);
        end
      S_WAIT_DONE:
        if (!drv_busy) begin
          tmr_nx   = TW'(LETTER_GAP_CYC);
          state_nx = S_GAP;
        end
      S_GAP:
        // Leaves on the cycle the count reads 1, so the gap lasts exactly
        // the loaded number of cycles.
        if (tmr <= TW'(1)) state_nx = S_IDLE;
        else               tmr_nx   = tmr - TW'(1);
      default:
        state_nx = S_IDLE;
    endcase
  end

  assign morse_start   = (state == S_ISSUE);
  assign morse_len     = len_q;
  assign morse_pattern = pat_q;
  assign seq_busy      = (count != '0) || (state != S_IDLE);
  assign bad_char      = bad_nx;
  assign drv_err       = err_nx;

endmodule

// File: tb/tb_morse_char_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for morse_char_sequencer. Stimulus pushes the expected
// driver-facing event (start with len/pattern, bad_char, drv_err) into a
// queue; an independent monitor pops and compares whenever the DUT emits one.
// Gap parameters are shrunk (letter 10, word 20) to keep the run short.
module tb_morse_char_sequencer;
  localparam int DEPTH = 8, LG = 10, WG = 20, ACK = 16, BUSY_CYC = 10;
  localparam logic [1:0] K_START = 2'd0, K_BAD = 2'd1, K_ERR = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [2:0] len;
    logic [4:0] pat;
  } exp_t;

  logic       clk = 0, rst_n = 0, char_valid = 0;
  logic [7:0] char_data = 0;
  logic       char_ready, morse_start, seq_busy, bad_char, drv_err, drv_busy;
  logic [2:0] morse_len;
  logic [4:0] morse_pattern;
  logic [3:0] fifo_count;
  logic       emu_busy = 0, drv_hold = 0, drv_en = 0;

  int   n_chk = 0, n_fail = 0, cyc = 0;
  int   fall_cyc = -1000, saf = 0, last_start = 0, last_bad = 0, prev_bad = 0, last_err = 0;
  exp_t sb[$];

  morse_char_sequencer #(.FIFO_DEPTH(DEPTH), .LETTER_GAP_CYC(LG),
                         .WORD_GAP_CYC(WG), .ACK_TIMEOUT(ACK)) dut (
    .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .morse_start(morse_start), .morse_len(morse_len),
    .morse_pattern(morse_pattern), .drv_busy(drv_busy), .seq_busy(seq_busy),
    .bad_char(bad_char), .drv_err(drv_err), .fifo_count(fifo_count));

  assign drv_busy = emu_busy | drv_hold;

  always #20 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Driver model: busy rises 2 cycles after start, stays up BUSY_CYC cycles.
  initial forever begin
    @(negedge clk);
    if (drv_en && rst_n && morse_start) begin
      repeat (2) @(negedge clk);
      emu_busy = 1;
      repeat (BUSY_CYC) @(negedge clk);
      emu_busy = 0;
      fall_cyc = cyc;
    end
  end

  function automatic exp_t mk(input logic [1:0] k, input logic [2:0] l, input logic [4:0] p);
    exp_t e;
    e.kind = k; e.len = l; e.pat = p;
    return e;
  endfunction

  task automatic take(input logic [1:0] k);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got kind=%0d len=%0d pat=%b, want no event", k, morse_len, morse_pattern);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || (k == K_START && (e.len != morse_len || e.pat != morse_pattern))) begin
        n_fail++;
        $display("FAIL sb_event: got kind=%0d len=%0d pat=%b, want kind=%0d len=%0d pat=%b",
                 k, morse_len, morse_pattern, e.kind, e.len, e.pat);
      end
    end
  endtask

  // Monitor
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (morse_start) begin last_start = cyc; saf = cyc - fall_cyc; take(K_START); end
      if (bad_char)    begin prev_bad = last_bad; last_bad = cyc; take(K_BAD); end
      if (drv_err)     begin last_err = cyc; take(K_ERR); end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge with
  // char_valid still high. acc gets the index of the accept edge.
  task automatic put_char(input logic [7:0] c, input logic has_exp, input exp_t e, output int acc);
    int w;
    w = 0;
    char_valid = 1; char_data = c;
    while (!char_ready && w < 2000) begin @(negedge clk); w++; end
    if (!char_ready) chk("put_timeout", 0, 1);
    acc = cyc + 1;
    if (has_exp) sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_in();
    char_valid = 0;
  endtask

  task automatic wait_idle(output int icyc);
    int w;
    w = 0;
    icyc = -1;
    while (w < 5000) begin
      @(negedge clk);
      w++;
      if (!seq_busy && !drv_busy) begin icyc = cyc; break; end
    end
    if (icyc < 0) chk("idle_timeout", 0, 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, char_ready, 1);
    chk({tag, "_start"}, morse_start, 0);
    chk({tag, "_len"}, morse_len, 0);
    chk({tag, "_pat"}, morse_pattern, 0);
    chk({tag, "_seq_busy"}, seq_busy, 0);
    chk({tag, "_bad"}, bad_char, 0);
    chk({tag, "_err"}, drv_err, 0);
    chk({tag, "_count"}, fifo_count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   acc, icyc;
    exp_t nx;
    logic [7:0] str9 [9];
    exp_t       exp9 [9];
    nx = '0;
    str9 = '{"A", "B", "C", "D", "E", "F", "G", "H", "I"};
    exp9 = '{mk(K_START,2,5'b00010), mk(K_START,4,5'b00001), mk(K_START,4,5'b00101),
             mk(K_START,3,5'b00001), mk(K_START,1,5'b00000), mk(K_START,4,5'b00100),
             mk(K_START,3,5'b00011), mk(K_START,4,5'b00000), mk(K_START,2,5'b00000)};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    rst_n = 1;
    drv_en = 1;
    @(negedge clk);

    // 'E': start in the cycle after edge acc+2, then exactly LG idle cycles.
    put_char("E", 1, mk(K_START, 1, 5'b00000), acc);
    idle_in();
    wait_idle(icyc);
    chk("e_start_latency", last_start - acc, 2);
    chk("e_gap_to_idle", icyc - fall_cyc, LG + 1);

    // 'a','K': case folding and start-to-start spacing after busy falls.
    put_char("a", 1, mk(K_START, 2, 5'b00010), acc);
    put_char("K", 1, mk(K_START, 3, 5'b00101), acc);
    idle_in();
    wait_idle(icyc);
    chk("k_after_fall", saf, LG + 3);

    // 'A',' ','B': letter gap, then IDLE+FETCH, word gap, IDLE+FETCH, ISSUE.
    put_char("A", 1, mk(K_START, 2, 5'b00010), acc);
    put_char(" ", 0, nx, acc);
    put_char("B", 1, mk(K_START, 4, 5'b00001), acc);
    idle_in();
    wait_idle(icyc);
    chk("b_after_fall", saf, LG + WG + 5);

    // Unsupported characters: no start, no gap between the bad pulses.
    put_char("#", 1, mk(K_BAD, 0, 0), acc);
`ifdef MORSE_DIGITS_EN
    put_char("5", 1, mk(K_START, 5, 5'b00000), acc);
    put_char("0", 1, mk(K_START, 5, 5'b11111), acc);
    idle_in();
    wait_idle(icyc);
`else
    put_char("5", 1, mk(K_BAD, 0, 0), acc);
    put_char("0", 1, mk(K_BAD, 0, 0), acc);
    idle_in();
    wait_idle(icyc);
    chk("bad_spacing", last_bad - prev_bad, 2);
`endif

    // FIFO full: park the FSM in WAIT_DONE with busy held, then fill.
    drv_en = 0;
    drv_hold = 1;
    put_char("T", 1, mk(K_START, 1, 5'b00001), acc);
    idle_in();
    repeat (6) @(negedge clk);
    for (int i = 0; i < 8; i++) put_char(str9[i], 1, exp9[i], acc);
    chk("full_count", fifo_count, 8);
    chk("full_ready", char_ready, 0);
    fork
      put_char(str9[8], 1, exp9[8], acc);
      begin
        repeat (3) @(negedge clk);
        chk("stall_count", fifo_count, 8);
        chk("stall_ready", char_ready, 0);
        drv_en = 1;
        drv_hold = 0;
      end
    join
    idle_in();
    chk("ninth_count", fifo_count, 8);
    chk("ninth_ready", char_ready, 0);
    wait_idle(icyc);
    chk("drain_count", fifo_count, 0);

    // Driver never acknowledges.
    drv_en = 0;
    put_char("N", 1, mk(K_START, 2, 5'b00001), acc);
    sb.push_back(mk(K_ERR, 0, 0));
    idle_in();
    wait_idle(icyc);
    chk("ack_timeout", last_err - last_start, ACK);

    // Reset in the middle of a word gap with letters still queued; none of
    // them may come out afterwards.
    put_char(" ", 0, nx, acc);
    put_char("E", 0, nx, acc);
    put_char("E", 0, nx, acc);
    idle_in();
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", seq_busy, 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk_reset("midrst");
    repeat (60) @(negedge clk);
    chk("post_rst_quiet", seq_busy, 0);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
